full_subtractor: RTL and testbench



---
 rtl/full_subtractor.sv | 51 +++++
 tb/tb_full_subtractor.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/full_subtractor.sv
// Registered ripple-borrow full subtractor: {bout, d} = a - b - bin, one cycle of latency.
// A valid input is captured into the output register; when in_valid is low, d/bout hold their previous values.
module full_subtractor #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             out_valid
);

    logic [WIDTH:0]   borrow;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] d_reg;
    logic             bout_reg;
    logic             out_valid_reg;

    assign borrow[0] = bin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            assign diff[gi]       = a[gi] ^ b[gi] ^ borrow[gi];
            assign borrow[gi + 1] = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & borrow[gi]);
        end
    endgenerate

    // Data registers load only on valid inputs, so unknowns on idle inputs never reach d/bout.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_reg         <= '0;
            bout_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                d_reg    <= diff;
                bout_reg <= borrow[WIDTH];
            end
        end
    end

    assign d         = d_reg;
    assign bout      = bout_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_full_subtractor.sv
// Directed table-driven bench for full_subtractor at WIDTH=1 (exhaustive) and WIDTH=8 (directed, hold, reset, random).
module tb_full_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       a1, b1, bin1, iv1;
    logic       d1, bout1, ov1;
    logic [7:0] a8, b8, d8;
    logic       bin8, iv8, bout8, ov8;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    full_subtractor #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .bin(bin1), .in_valid(iv1),
        .d(d1), .bout(bout1), .out_valid(ov1)
    );

    full_subtractor #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .bin(bin8), .in_valid(iv8),
        .d(d8), .bout(bout8), .out_valid(ov8)
    );

    typedef struct {
        logic a, b, bin;
        logic d, bout;
    } vec1_t;

    typedef struct {
        logic [7:0] a, b;
        logic       bin;
        logic [7:0] d;
        logic       bout;
    } vec8_t;

    vec1_t t1[8];
    vec8_t t8[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string name, input logic [7:0] ed, input logic eb, input logic ev);
        chk({name, ".d"}, 32'(d8), 32'(ed));
        chk({name, ".bout"}, 32'(bout8), 32'(eb));
        chk({name, ".out_valid"}, 32'(ov8), 32'(ev));
    endtask

    initial begin
        logic [8:0] r;
        logic [7:0] exp_d;
        logic       exp_b;
        logic       v;

        t1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        t1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        t1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        t1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        t1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        t1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        t1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        t1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        t8[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
        t8[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
        t8[2] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
        t8[3] = '{8'h80, 8'h80, 1'b1, 8'hFF, 1'b1};

        // Reset with valid, nonzero inputs present
        rst = 1'b1;
        a1 = 1'b1; b1 = 1'b0; bin1 = 1'b0; iv1 = 1'b1;
        a8 = 8'h03; b8 = 8'h05; bin8 = 1'b1; iv8 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            $display("[TB] reset cycle %0d: d8=%h bout8=%b ov8=%b d1=%b ov1=%b", i, d8, bout8, ov8, d1, ov1);
            chk8("reset", 8'h00, 1'b0, 1'b0);
            chk("reset.d1", 32'(d1), 32'd0);
            chk("reset.bout1", 32'(bout1), 32'd0);
            chk("reset.ov1", 32'(ov1), 32'd0);
        end
        rst = 1'b0;
        iv8 = 1'b0;

        // WIDTH=1 exhaustive, back-to-back
        for (int i = 0; i < 8; i++) begin
            a1 = t1[i].a; b1 = t1[i].b; bin1 = t1[i].bin; iv1 = 1'b1;
            step();
            $display("[TB] w1 a=%b b=%b bin=%b -> d=%b bout=%b ov=%b", a1, b1, bin1, d1, bout1, ov1);
            chk("w1.d", 32'(d1), 32'(t1[i].d));
            chk("w1.bout", 32'(bout1), 32'(t1[i].bout));
            chk("w1.ov", 32'(ov1), 32'd1);
        end
        iv1 = 1'b0;

        // WIDTH=8 directed, back-to-back
        for (int i = 0; i < 4; i++) begin
            a8 = t8[i].a; b8 = t8[i].b; bin8 = t8[i].bin; iv8 = 1'b1;
            step();
            $display("[TB] w8 a=%h b=%h bin=%b -> d=%h bout=%b", a8, b8, bin8, d8, bout8);
            chk8("w8dir", t8[i].d, t8[i].bout, 1'b1);
        end

        // Hold: capture 0x5A-0x13-1 = 0x46, then idle with toggling inputs
        a8 = 8'h5A; b8 = 8'h13; bin8 = 1'b1; iv8 = 1'b1;
        a1 = 1'b0; b1 = 1'b1; bin1 = 1'b0; iv1 = 1'b1;
        step();
        chk8("hold.capture", 8'h46, 1'b0, 1'b1);
        chk("hold.capture.d1", 32'(d1), 32'd1);
        iv8 = 1'b0; iv1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a8 = ~a8; b8 = b8 + 8'h71; bin8 = ~bin8;
            a1 = ~a1; bin1 = ~bin1;
            step();
            $display("[TB] hold cycle %0d: d8=%h bout8=%b ov8=%b", i, d8, bout8, ov8);
            chk8("hold", 8'h46, 1'b0, 1'b0);
            chk("hold.d1", 32'(d1), 32'd1);
            chk("hold.bout1", 32'(bout1), 32'd1);
            chk("hold.ov1", 32'(ov1), 32'd0);
        end

        // Reset mid-stream
        a8 = 8'h10; b8 = 8'h20; bin8 = 1'b0; iv8 = 1'b1;
        step();
        chk8("mid.pre", 8'hF0, 1'b1, 1'b1);
        rst = 1'b1; a8 = 8'h01; b8 = 8'h01; bin8 = 1'b1;
        step();
        $display("[TB] mid-stream reset: d8=%h bout8=%b ov8=%b", d8, bout8, ov8);
        chk8("mid.reset", 8'h00, 1'b0, 1'b0);
        rst = 1'b0; a8 = 8'h30; b8 = 8'h0F; bin8 = 1'b1;
        step();
        $display("[TB] post-reset a=30 b=0F bin=1 -> d=%h bout=%b", d8, bout8);
        chk8("mid.post", 8'h20, 1'b0, 1'b1);

        // Random valid/invalid traffic against arithmetic reference
        exp_d = 8'h20; exp_b = 1'b0;
        for (int i = 0; i < 200; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            v = ($urandom_range(0, 3) != 0);
            iv8 = v;
            if (v) begin
                r = {1'b0, a8} - {1'b0, b8} - {8'd0, bin8};
                exp_d = r[7:0];
                exp_b = r[8];
            end
            step();
            $display("[TB] rand %0d v=%b a=%h b=%h bin=%b -> d=%h bout=%b", i, v, a8, b8, bin8, d8, bout8);
            chk8("rand", exp_d, exp_b, v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
